hazard_scoreboard: RTL



---
 rtl/hazard_scoreboard_pkg.sv | 12 +
 rtl/sb_reg_counter.sv | 27 ++
 rtl/hazard_scoreboard.sv | 114 +++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and default sizing for the RAW hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int unsigned SB_NUM_REGS     = 8;
  localparam int unsigned SB_REG_W        = 3;
  localparam int unsigned SB_MAX_INFLIGHT = 3;
  localparam int unsigned SB_CNT_W        = $clog2(SB_MAX_INFLIGHT + 1);

  typedef logic [SB_REG_W-1:0] lc3b_reg;
  typedef logic [SB_CNT_W-1:0] scoreboard_cnt_t;

endpackage

// File: rtl/sb_reg_counter.sv
// Single-register in-flight write counter: saturating up/down with synchronous clear.
module sb_reg_counter #(
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned MAX_CNT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             nonzero
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && !dec && (cnt != CNT_W'(MAX_CNT))) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign nonzero = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight destination writes per register and stalls decode on RAW
// hazards or when a register already has the maximum number of writes pending.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REGS     = SB_NUM_REGS,
  parameter int unsigned REG_W        = SB_REG_W,
  parameter int unsigned MAX_INFLIGHT = SB_MAX_INFLIGHT,
  parameter bit          FWD_EN       = 1'b1,
  localparam int unsigned CNT_W       = $clog2(MAX_INFLIGHT + 1),
  localparam int unsigned TOT_W       = CNT_W + REG_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic                produces_dr,
  input  logic                need_sr1,
  input  logic                need_sr2,
  input  logic                need_hsr,
  input  logic [REG_W-1:0]    dr,
  input  logic [REG_W-1:0]    sr1,
  input  logic [REG_W-1:0]    sr2,
  input  logic [REG_W-1:0]    hsr,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    wb_dr,
  input  logic                flush,
  output logic                stall,
  output logic                issue_fire,
  output logic [NUM_REGS-1:0] pending,
  output logic [TOT_W-1:0]    inflight_total,
  output logic                wb_err
);

  logic [CNT_W-1:0]    cnt_arr [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic [CNT_W-1:0]    cnt_sr1, cnt_sr2, cnt_hsr, cnt_dr, cnt_wb;
  logic                hz_sr1, hz_sr2, hz_hsr, hz_struct;

  for (genvar r = 0; r < int'(NUM_REGS); r++) begin : gen_cnt
    sb_reg_counter #(
      .CNT_W   (CNT_W),
      .MAX_CNT (MAX_INFLIGHT)
    ) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .clr     (flush),
      .inc     (inc_vec[r]),
      .dec     (dec_vec[r]),
      .cnt     (cnt_arr[r]),
      .nonzero (pending[r])
    );
  end

  // Counter lookups for every index compared this cycle.
  always_comb begin
    cnt_sr1 = '0;
    cnt_sr2 = '0;
    cnt_hsr = '0;
    cnt_dr  = '0;
    cnt_wb  = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (sr1   == REG_W'(r)) cnt_sr1 = cnt_arr[r];
      if (sr2   == REG_W'(r)) cnt_sr2 = cnt_arr[r];
      if (hsr   == REG_W'(r)) cnt_hsr = cnt_arr[r];
      if (dr    == REG_W'(r)) cnt_dr  = cnt_arr[r];
      if (wb_dr == REG_W'(r)) cnt_wb  = cnt_arr[r];
    end
  end

  // A retiring last write to a source clears its hazard when bypass is on.
  always_comb begin
    hz_sr1 = need_sr1 && (cnt_sr1 != '0) &&
             !(FWD_EN && wb_valid && (wb_dr == sr1) && (cnt_sr1 == CNT_W'(1)));
    hz_sr2 = need_sr2 && (cnt_sr2 != '0) &&
             !(FWD_EN && wb_valid && (wb_dr == sr2) && (cnt_sr2 == CNT_W'(1)));
    hz_hsr = need_hsr && (cnt_hsr != '0) &&
             !(FWD_EN && wb_valid && (wb_dr == hsr) && (cnt_hsr == CNT_W'(1)));
    hz_struct = produces_dr && (cnt_dr == CNT_W'(MAX_INFLIGHT)) &&
                !(wb_valid && (wb_dr == dr));
  end

  assign stall      = issue_valid && !flush && !reset &&
                      (hz_sr1 || hz_sr2 || hz_hsr || hz_struct);
  assign issue_fire = issue_valid && !stall && !flush;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      inc_vec[r] = issue_fire && produces_dr && (dr == REG_W'(r));
      dec_vec[r] = wb_valid && (wb_dr == REG_W'(r)) && pending[r];
    end
  end

  // Issue can only be blocked by saturation when no matching writeback is
  // present, so at most one increment and one decrement land per cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      inflight_total <= '0;
    end else begin
      inflight_total <= inflight_total + TOT_W'(|inc_vec) - TOT_W'(|dec_vec);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_err <= 1'b0;
    end else if (wb_valid && (cnt_wb == '0)) begin
      wb_err <= 1'b1;
    end
  end

endmodule
